// File: rtl/rv32_alu_sequencer.sv
// Two-pass 32-bit ALU sequencer driving a shared 16-bit add/logic unit.
// Low half first, then high half with the registered carry; result returned over valid/ready.
module rv32_alu_sequencer #(
    parameter int XLEN = 32,
    parameter int HALF = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic [HALF-1:0] o_au_operand_one,
    output logic [HALF-1:0] o_au_operand_two,
    output logic            o_au_c_in,
    output logic [1:0]      o_au_sel,
    input  logic [HALF-1:0] i_au_result,
    input  logic            i_au_carry_out,
    output logic [1:0]      o_dbg_state
);
    if (XLEN != 2 * HALF) begin : g_width_check
        $error("XLEN must equal 2*HALF");
    end

    // Handshake: a request transfers on a rising edge where i_valid & o_ready;
    // a result transfers on a rising edge where o_valid & i_ready.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LO = 2'd1, ST_HI = 2'd2, ST_DONE = 2'd3} state_t;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              carry_q, carry_d;
    logic [HALF-1:0]   res_lo_q, res_lo_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    function automatic logic is_logic(input logic [2:0] op);
        return (op == OP_OR) || (op == OP_AND) || (op == OP_XOR);
    endfunction

    function automatic logic [1:0] sel_of(input logic [2:0] op);
        case (op)
            OP_OR:   return 2'b01;
            OP_AND:  return 2'b10;
            OP_XOR:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    logic sum31, ovf;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        a_d              = a_q;
        b_d              = b_q;
        carry_d          = carry_q;
        res_lo_d         = res_lo_q;
        result_d         = result_q;
        o_au_operand_one = '0;
        o_au_operand_two = '0;
        o_au_c_in        = 1'b0;
        o_au_sel         = 2'b00;
        sum31            = i_au_result[HALF-1];
        ovf              = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum31 != a_q[XLEN-1]);

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    op_d    = i_op;
                    a_d     = i_rs1;
                    b_d     = is_sub(i_op) ? ~i_rs2 : i_rs2;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                o_au_operand_one = a_q[HALF-1:0];
                o_au_operand_two = b_q[HALF-1:0];
                o_au_c_in        = is_sub(op_q);
                o_au_sel         = sel_of(op_q);
                res_lo_d         = i_au_result;
                // Logic ops never chain, so their high pass always sees c_in=0.
                carry_d          = i_au_carry_out & ~is_logic(op_q);
                state_d          = ST_HI;
            end
            ST_HI: begin
                o_au_operand_one = a_q[XLEN-1:HALF];
                o_au_operand_two = b_q[XLEN-1:HALF];
                o_au_c_in        = carry_q;
                o_au_sel         = sel_of(op_q);
                case (op_q)
                    OP_SLTU: result_d = {{(XLEN-1){1'b0}}, ~i_au_carry_out};
                    OP_SLT:  result_d = {{(XLEN-1){1'b0}}, sum31 ^ ovf};
                    OP_RSVD: result_d = '0;
                    default: result_d = {i_au_result, res_lo_q};
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            res_lo_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            res_lo_q <= res_lo_d;
            result_q <= result_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_valid     = (state_q == ST_DONE);
    assign o_result    = result_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// Bench for rv32_alu_sequencer: models the 16-bit unit, checks per-pass unit drives
// and compares results against a queue of reference-model expectations.
module tb_rv32_alu_sequencer;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_busy;
    logic [15:0] o_au_operand_one;
    logic [15:0] o_au_operand_two;
    logic        o_au_c_in;
    logic [1:0]  o_au_sel;
    logic [15:0] i_au_result;
    logic        i_au_carry_out;
    logic [1:0]  o_dbg_state;

    rv32_alu_sequencer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_op             (i_op),
        .i_rs1            (i_rs1),
        .i_rs2            (i_rs2),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_result         (o_result),
        .o_busy           (o_busy),
        .o_au_operand_one (o_au_operand_one),
        .o_au_operand_two (o_au_operand_two),
        .o_au_c_in        (o_au_c_in),
        .o_au_sel         (o_au_sel),
        .i_au_result      (i_au_result),
        .i_au_carry_out   (i_au_carry_out),
        .o_dbg_state      (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- shared 16-bit unit model ----------------
    logic [16:0] au_sum;
    always_comb begin
        au_sum = 17'd0;
        case (o_au_sel)
            2'b00: au_sum = {1'b0, o_au_operand_one} + {1'b0, o_au_operand_two} + {16'd0, o_au_c_in};
            2'b01: au_sum = {1'b0, o_au_operand_one | o_au_operand_two};
            2'b10: au_sum = {1'b0, o_au_operand_one & o_au_operand_two};
            2'b11: au_sum = {1'b0, o_au_operand_one ^ o_au_operand_two};
            default: au_sum = 17'd0;
        endcase
    end
    assign i_au_result    = au_sum[15:0];
    assign i_au_carry_out = au_sum[16];

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            3'b011:  return a & b;
            3'b100:  return a ^ b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_sub(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b101) || (op == 3'b110);
    endfunction

    function automatic logic [1:0] model_sel(input logic [2:0] op);
        case (op)
            3'b010:  return 2'b01;
            3'b011:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit chain_next);
        logic [31:0] bp;
        logic [16:0] lo;
        logic [31:0] exp;
        int n;
        n = 0;
        while (!o_ready && n < 20) begin
            step();
            n++;
        end
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        step();
        exp_q.push_back(model_result(op, a, b));
        i_valid = 1'b0;
        i_op  = 3'($urandom_range(0, 7));
        i_rs1 = $urandom;
        i_rs2 = $urandom;
        bp = model_sub(op) ? ~b : b;
        lo = {1'b0, a[15:0]} + {1'b0, bp[15:0]} + {16'd0, model_sub(op)};
        // LO pass
        check("lo_state", {30'd0, o_dbg_state}, 32'd1);
        check("lo_flags", {29'd0, o_ready, o_busy, o_valid}, 32'b010);
        check("lo_operands", {o_au_operand_one, o_au_operand_two}, {a[15:0], bp[15:0]});
        check("lo_c_in", {31'd0, o_au_c_in}, {31'd0, model_sub(op)});
        check("lo_sel", {30'd0, o_au_sel}, {30'd0, model_sel(op)});
        step();
        // HI pass
        check("hi_state", {30'd0, o_dbg_state}, 32'd2);
        check("hi_operands", {o_au_operand_one, o_au_operand_two}, {a[31:16], bp[31:16]});
        check("hi_sel", {30'd0, o_au_sel}, {30'd0, model_sel(op)});
        if (model_sel(op) != 2'b00) check("hi_c_in_logic", {31'd0, o_au_c_in}, 32'd0);
        else if (op != 3'b111)      check("hi_c_in_carry", {31'd0, o_au_c_in}, {31'd0, lo[16]});
        step();
        // DONE
        exp = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        check("done_valid", {31'd0, o_valid}, 32'd1);
        check("done_au_idle", {o_au_operand_one, o_au_operand_two} | {29'd0, o_au_c_in, o_au_sel}, 32'd0);
        i_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            step();
            check("bp_flags", {29'd0, o_ready, o_busy, o_valid}, 32'b011);
            check("bp_result", o_result, exp);
        end
        if (chain_next) begin
            i_valid = 1'b1;
            i_op = 3'($urandom_range(0, 7));
        end
        i_ready = 1'b1;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("result", o_result, exp);
        step();
        i_ready = 1'b0;
        check("after_state", {30'd0, o_dbg_state}, 32'd0);
        check("after_flags", {29'd0, o_ready, o_busy, o_valid}, 32'b100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
        step();
        step();
        check("rst_state", {30'd0, o_dbg_state}, 32'd0);
        check("rst_flags", {29'd0, o_ready, o_busy, o_valid}, 32'b100);
        check("rst_result", o_result, 32'd0);
        check("rst_au", {o_au_operand_one, o_au_operand_two} | {29'd0, o_au_c_in, o_au_sel}, 32'd0);
        i_rst = 1'b0;
        step();

        run_op(3'b000, 32'h0000_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op(3'b001, 32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        run_op(3'b110, 32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        run_op(3'b101, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
        run_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_op(3'b010, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 1'b0);
        run_op(3'b011, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 1'b0);
        run_op(3'b100, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 1'b0);
        run_op(3'b111, 32'h1234_5678, 32'h1111_1111, 0, 1'b0);
        // Backpressure, then a request already pending as the result is taken
        run_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5, 1'b1);
        run_op(3'b001, 32'h0000_0005, 32'h0000_0007, 0, 1'b0);
        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_op(3'($urandom_range(0, 6)), $urandom, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset while the high pass is in flight
        i_valid = 1'b1; i_op = 3'b000; i_rs1 = 32'h0001_0001; i_rs2 = 32'h0002_0002;
        step();
        exp_q.push_back(model_result(3'b000, 32'h0001_0001, 32'h0002_0002));
        i_valid = 1'b0;
        step();
        check("pre_rst_hi", {30'd0, o_dbg_state}, 32'd2);
        i_rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("midrst_state", {30'd0, o_dbg_state}, 32'd0);
        check("midrst_flags", {29'd0, o_ready, o_busy, o_valid}, 32'b100);
        check("midrst_result", o_result, 32'd0);
        check("midrst_au", {o_au_operand_one, o_au_operand_two} | {29'd0, o_au_c_in, o_au_sel}, 32'd0);
        step();
        i_rst = 1'b0;
        step();
        check("midrst_idle", {30'd0, o_dbg_state}, 32'd0);
        run_op(3'b001, 32'h0000_0010, 32'h0000_0001, 0, 1'b0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
